// File: rtl/poly_small_pkg.sv
// Shared definitions for the small-polynomial squared-norm link:
// width helpers, default limits and the stream-source state encoding.
package poly_small_pkg;

  localparam int DEFAULT_LOGN    = 9;
  localparam int DEFAULT_TIMEOUT = 2000;
  localparam int DEFAULT_GAP     = 2;
  localparam int N               = 1 << DEFAULT_LOGN;

  // Coefficient width (two's complement) for a given log2 degree.
  function automatic int f_bit(input int logn);
    return (logn == 9) ? 7 : 6;
  endfunction

  // Squared-norm width (unsigned) for a given log2 degree.
  function automatic int s_bit(input int logn);
    return (logn == 9) ? 21 : 20;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_e;

endpackage

// File: rtl/poly_small_stream_src.sv
// Streams N coefficients from RAM into the sqnorm accumulator, captures the final
// running sum and reports accept/reject against BOUND plus timeout/protocol errors.
module poly_small_stream_src
  import poly_small_pkg::*;
#(
  parameter int          LOGN    = DEFAULT_LOGN,
  parameter int          F_BIT   = f_bit(LOGN),
  parameter int          S_BIT   = s_bit(LOGN),
  parameter int unsigned BOUND   = 1 << (S_BIT - 1),
  parameter int          TIMEOUT = DEFAULT_TIMEOUT,
  parameter int          GAP     = DEFAULT_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             ok,
  output logic             err,
  output logic [S_BIT-1:0] sqnorm,
  output logic             ram_re,
  output logic [LOGN-1:0]  ram_addr,
  input  logic [F_BIT-1:0] ram_rdata,
  output logic             ena,
  output logic             f_valid,
  output logic [F_BIT-1:0] f,
  input  logic             s_valid,
  input  logic [S_BIT-1:0] s
);

  localparam int N_COEF  = 1 << LOGN;
  localparam int CNT_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int TCNT_W  = $clog2(CNT_MAX + 1);

  localparam logic [TCNT_W-1:0] TCNT_ONE     = TCNT_W'(1);
  localparam logic [TCNT_W-1:0] TCNT_TIMEOUT = TCNT_W'(TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_GAP     = TCNT_W'(GAP);
  localparam logic [LOGN-1:0]   IDX_ONE      = LOGN'(1);
  localparam logic [LOGN-1:0]   IDX_LAST     = LOGN'(N_COEF - 1);
  localparam logic [S_BIT-1:0]  BOUND_S      = S_BIT'(BOUND);

  state_e            state_q,   state_d;
  logic [LOGN-1:0]   idx_q,     idx_d;
  logic [TCNT_W-1:0] tcnt_q,    tcnt_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              ok_q,      ok_d;
  logic              err_q,     err_d;
  logic [S_BIT-1:0]  sqnorm_q,  sqnorm_d;
  logic              ram_re_q,  ram_re_d;
  logic              ena_q,     ena_d;
  logic              f_valid_q, f_valid_d;
  logic [F_BIT-1:0]  f_q,       f_d;

  always_comb begin
    // NOTE: every _d starts from its _q (or its idle value for pulses) so no path
    // through the case statement leaves a signal unassigned and infers a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    tcnt_d    = tcnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ok_d      = ok_q;
    err_d     = err_q;
    sqnorm_d  = sqnorm_q;
    ram_re_d  = 1'b0;
    ena_d     = ena_q;
    f_valid_d = 1'b0;
    f_d       = f_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FETCH;
          busy_d   = 1'b1;
          idx_d    = '0;
          err_d    = 1'b0;
          ok_d     = 1'b0;
          ram_re_d = 1'b1;
          ena_d    = 1'b1;
        end
      end

      S_FETCH: begin
        state_d = S_SEND;
        if (s_valid) err_d = 1'b1;
      end

      S_SEND: begin
        state_d   = S_WAIT;
        f_d       = ram_rdata;
        f_valid_d = 1'b1;
        tcnt_d    = TCNT_ONE;
        if (s_valid) err_d = 1'b1;
      end

      // A response on the timeout boundary cycle is still accepted.
      S_WAIT: begin
        if (s_valid) begin
          sqnorm_d = s;
          if (idx_q == IDX_LAST) begin
            state_d = S_GAP;
            ena_d   = 1'b0;
            tcnt_d  = TCNT_ONE;
          end else begin
            state_d  = S_FETCH;
            idx_d    = idx_q + IDX_ONE;
            ram_re_d = 1'b1;
          end
        end else if (tcnt_q == TCNT_TIMEOUT) begin
          state_d = S_GAP;
          err_d   = 1'b1;
          ena_d   = 1'b0;
          tcnt_d  = TCNT_ONE;
        end else begin
          tcnt_d = tcnt_q + TCNT_ONE;
        end
      end

      // Holding ena low here is what clears the downstream accumulator.
      S_GAP: begin
        if (tcnt_q == TCNT_GAP) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          ok_d    = !err_q && (sqnorm_q <= BOUND_S);
        end else begin
          tcnt_d = tcnt_q + TCNT_ONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      tcnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      sqnorm_q  <= '0;
      ram_re_q  <= 1'b0;
      ena_q     <= 1'b0;
      f_valid_q <= 1'b0;
      f_q       <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tcnt_q    <= tcnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      sqnorm_q  <= sqnorm_d;
      ram_re_q  <= ram_re_d;
      ena_q     <= ena_d;
      f_valid_q <= f_valid_d;
      f_q       <= f_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ok       = ok_q;
  assign err      = err_q;
  assign sqnorm   = sqnorm_q;
  assign ram_re   = ram_re_q;
  assign ram_addr = idx_q;
  assign ena      = ena_q;
  assign f_valid  = f_valid_q;
  assign f        = f_q;

endmodule
